// File: rtl/wb_regfile.sv
// Writeback stage: MEM/WB register, MemtoReg select, and the general register
// file with two bypassed combinational read ports.

module wb_regfile_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]                    idx_i,
  input  logic                                 wb_en_i,
  input  logic [ADDR_W-1:0]                    wb_reg_i,
  input  logic [DATA_W-1:0]                    wb_data_i,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   regs_i,
  output logic [DATA_W-1:0]                    data_o
);
  // Pending write wins over the array so readers never see a stale value
  // in the cycle before commit.
  always_comb begin
    data_o = regs_i[idx_i];
    if ((ZERO_REG != 0) && (idx_i == '0))
      data_o = '0;
    else if (wb_en_i && (idx_i == wb_reg_i))
      data_o = wb_data_i;
  end
endmodule

module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;

  logic              wb_en_q,   wb_en_d;
  logic [ADDR_W-1:0] wb_reg_q,  wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [DEPTH-1:0][DATA_W-1:0]  regs_q;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_idx;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

  // MEM/WB capture; a write aimed at a hard-wired zero register is dropped here
  always_comb begin
    wb_en_d   = wb_en_q;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    if (!stall) begin
      wb_en_d   = RegWrite & ~((ZERO_REG != 0) && (write_reg == '0));
      wb_reg_d  = write_reg;
      wb_data_d = MemtoReg ? mem_data : alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Commit runs even under stall; a held entry just rewrites the same value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      regs_q <= '0;
    else if (wb_en_q)
      regs_q[wb_reg_q] <= wb_data_q;
  end

  assign rd_idx[0] = read_reg1;
  assign rd_idx[1] = read_reg2;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    wb_regfile_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .idx_i    (rd_idx[g]),
      .wb_en_i  (wb_en_q),
      .wb_reg_i (wb_reg_q),
      .wb_data_i(wb_data_q),
      .regs_i   (regs_q),
      .data_o   (rd_data[g])
    );
  end

  assign read_data1 = rd_data[0];
  assign read_data2 = rd_data[1];
  assign wb_en      = wb_en_q;
  assign wb_reg     = wb_reg_q;
  assign wb_data    = wb_data_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes expectations, a negedge
// monitor drains and compares them.

module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        RegWrite;
  logic        MemtoReg;
  logic [4:0]  write_reg;
  logic [31:0] alu_result;
  logic [31:0] mem_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .RegWrite  (RegWrite),
    .MemtoReg  (MemtoReg),
    .write_reg (write_reg),
    .alu_result(alu_result),
    .mem_data  (mem_data),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  localparam int S_RD1 = 0, S_RD2 = 1, S_EN = 2, S_REG = 3, S_DAT = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_val(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Inputs change just after the rising edge; the monitor samples at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        exp_t        e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.sel)
          S_RD1:   act = read_data1;
          S_RD2:   act = read_data2;
          S_EN:    act = {31'd0, wb_en};
          S_REG:   act = {27'd0, wb_reg};
          default: act = wb_data;
        endcase
        n_cmp++;
        if (act !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
    write_reg = '0; alu_result = '0; mem_data = '0;
    read_reg1 = '0; read_reg2 = '0;

    tick();
    expect_val("rst_wb_en", S_EN, 32'd0);
    expect_val("rst_wb_data", S_DAT, 32'd0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      tick();
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      expect_val("rst_rd1", S_RD1, 32'd0);
      expect_val("rst_rd2", S_RD2, 32'd0);
      expect_val("rst_en", S_EN, 32'd0);
    end

    // ALU result to r5
    tick();
    RegWrite = 1'b1; MemtoReg = 1'b0; write_reg = 5'd5;
    alu_result = 32'h0000_1234; mem_data = 32'hDEAD_BEEF; read_reg1 = 5'd5;
    expect_val("r5_pre", S_RD1, 32'd0);
    tick();
    RegWrite = 1'b0;
    expect_val("r5_e1_en", S_EN, 32'd1);
    expect_val("r5_e1_reg", S_REG, 32'd5);
    expect_val("r5_e1_data", S_DAT, 32'h0000_1234);
    expect_val("r5_e1_bypass", S_RD1, 32'h0000_1234);
    tick();
    expect_val("r5_e2_en", S_EN, 32'd0);
    expect_val("r5_e2_array", S_RD1, 32'h0000_1234);

    // Load data to r7
    tick();
    RegWrite = 1'b1; MemtoReg = 1'b1; write_reg = 5'd7;
    alu_result = 32'h0000_0099; mem_data = 32'hCAFE_F00D; read_reg1 = 5'd7;
    tick();
    RegWrite = 1'b0;
    expect_val("r7_e1_data", S_DAT, 32'hCAFE_F00D);
    tick();
    expect_val("r7_e2_array", S_RD1, 32'hCAFE_F00D);
    expect_val("r7_e2_en", S_EN, 32'd0);

    // Write to r0 is dropped
    tick();
    RegWrite = 1'b1; MemtoReg = 1'b0; write_reg = 5'd0;
    alu_result = 32'hFFFF_FFFF; read_reg1 = 5'd0;
    tick();
    RegWrite = 1'b0;
    expect_val("r0_e1_en", S_EN, 32'd0);
    expect_val("r0_e1_rd", S_RD1, 32'd0);
    tick();
    expect_val("r0_e2_rd", S_RD1, 32'd0);

    // Back-to-back writes to r3
    tick();
    RegWrite = 1'b1; write_reg = 5'd3; alu_result = 32'h11; read_reg2 = 5'd3;
    tick();
    alu_result = 32'h22;
    expect_val("r3_e1", S_RD2, 32'h11);
    tick();
    RegWrite = 1'b0;
    expect_val("r3_e2_bypass", S_RD2, 32'h22);
    tick();
    read_reg1 = 5'd3;
    expect_val("r3_e3_array", S_RD2, 32'h22);
    expect_val("r3_e3_both", S_RD1, 32'h22);
    expect_val("r3_e3_en", S_EN, 32'd0);

    // Stall holds r9 while r10 is presented
    tick();
    RegWrite = 1'b1; write_reg = 5'd9; alu_result = 32'hA5A5_A5A5;
    tick();
    stall = 1'b1; write_reg = 5'd10; alu_result = 32'h1;
    read_reg1 = 5'd10; read_reg2 = 5'd9;
    expect_val("stl_cap_reg", S_REG, 32'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val("stl_hold_reg", S_REG, 32'd9);
      expect_val("stl_hold_en", S_EN, 32'd1);
      expect_val("stl_r10_unwritten", S_RD1, 32'd0);
      expect_val("stl_r9", S_RD2, 32'hA5A5_A5A5);
    end
    stall = 1'b0;
    tick();
    RegWrite = 1'b0;
    expect_val("stl_rel_reg", S_REG, 32'd10);
    expect_val("stl_rel_data", S_DAT, 32'h1);
    expect_val("stl_rel_bypass", S_RD1, 32'h1);
    expect_val("stl_r9_array", S_RD2, 32'hA5A5_A5A5);
    tick();
    expect_val("stl_r10_array", S_RD1, 32'h1);
    expect_val("stl_done_en", S_EN, 32'd0);

    // Asynchronous reset while r12 is pending
    tick();
    RegWrite = 1'b1; write_reg = 5'd12; alu_result = 32'h55; read_reg1 = 5'd12;
    tick();
    RegWrite = 1'b0;
    #2;
    rst_n = 1'b0;
    expect_val("arst_en", S_EN, 32'd0);
    expect_val("arst_reg", S_REG, 32'd0);
    expect_val("arst_data", S_DAT, 32'd0);
    expect_val("arst_rd1", S_RD1, 32'd0);
    expect_val("arst_rd2", S_RD2, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    expect_val("arst_r12_after", S_RD1, 32'd0);
    expect_val("arst_en_after", S_EN, 32'd0);
    tick();
    expect_val("arst_r12_later", S_RD1, 32'd0);
    expect_val("arst_r9_cleared", S_RD2, 32'd0);

    tick();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
